// File: rtl/kul8_err_monitor.sv
// Error-statistics monitor for the 8-bit Kulkarni approximate multiplier.
// Two-stage pipeline: register operands and exact product, then accumulate |a*b - y|.
module kul8_err_monitor #(
    parameter int N_SAMPLES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [15:0] y,
    output logic        busy,
    output logic        done,
    output logic [16:0] sample_cnt,
    output logic [16:0] correct_cnt,
    output logic [31:0] sum_ed,
    output logic [15:0] max_ed,
    output logic [7:0]  max_a,
    output logic [7:0]  max_b
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [16:0] N_LIM = 17'(N_SAMPLES);

    state_t      state_q, state_d;
    logic [16:0] acc_cnt_q, acc_cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        s1_valid_q, s1_valid_d;
    logic [7:0]  s1_a_q, s1_a_d;
    logic [7:0]  s1_b_q, s1_b_d;
    logic [15:0] s1_y_q, s1_y_d;
    logic [15:0] s1_p_q, s1_p_d;
    logic [16:0] sample_cnt_q, sample_cnt_d;
    logic [16:0] correct_cnt_q, correct_cnt_d;
    logic [31:0] sum_ed_q, sum_ed_d;
    logic [15:0] max_ed_q, max_ed_d;
    logic [7:0]  max_a_q, max_a_d;
    logic [7:0]  max_b_q, max_b_d;

    logic        accept;
    logic        accumulate;
    logic [15:0] ed;

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block infers a latch.
        state_d       = state_q;
        acc_cnt_d     = acc_cnt_q;
        s1_valid_d    = 1'b0;
        s1_a_d        = s1_a_q;
        s1_b_d        = s1_b_q;
        s1_y_d        = s1_y_q;
        s1_p_d        = s1_p_q;
        sample_cnt_d  = sample_cnt_q;
        correct_cnt_d = correct_cnt_q;
        sum_ed_d      = sum_ed_q;
        max_ed_d      = max_ed_q;
        max_a_d       = max_a_q;
        max_b_d       = max_b_q;

        ed         = (s1_p_q >= s1_y_q) ? (s1_p_q - s1_y_q) : (s1_y_q - s1_p_q);
        accept     = in_valid && in_ready_q && !start;
        accumulate = s1_valid_q && !start;

        if (start) begin
            // Abort or fresh window: the in-flight sample is dropped, not accumulated.
            state_d       = S_RUN;
            acc_cnt_d     = '0;
            sample_cnt_d  = '0;
            correct_cnt_d = '0;
            sum_ed_d      = '0;
            max_ed_d      = '0;
            max_a_d       = '0;
            max_b_d       = '0;
        end else begin
            s1_valid_d = accept;
            if (accept) begin
                s1_a_d    = a;
                s1_b_d    = b;
                s1_y_d    = y;
                s1_p_d    = {8'd0, a} * {8'd0, b};
                acc_cnt_d = acc_cnt_q + 17'd1;
            end
            if (accumulate) begin
                sample_cnt_d  = sample_cnt_q + 17'd1;
                correct_cnt_d = correct_cnt_q + {16'd0, (ed == 16'd0)};
                sum_ed_d      = sum_ed_q + {16'd0, ed};
                if (ed > max_ed_q) begin
                    max_ed_d = ed;
                    max_a_d  = s1_a_q;
                    max_b_d  = s1_b_q;
                end
            end
            case (state_q)
                S_RUN:   if (accept && (acc_cnt_q == N_LIM - 17'd1)) state_d = S_DRAIN;
                S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end

        in_ready_d = (state_d == S_RUN) && (acc_cnt_d < N_LIM);
        busy_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            // NOTE: datapath registers are reset too; rst must leave no trace of a partial window.
            state_q       <= S_IDLE;
            acc_cnt_q     <= '0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_a_q        <= '0;
            s1_b_q        <= '0;
            s1_y_q        <= '0;
            s1_p_q        <= '0;
            sample_cnt_q  <= '0;
            correct_cnt_q <= '0;
            sum_ed_q      <= '0;
            max_ed_q      <= '0;
            max_a_q       <= '0;
            max_b_q       <= '0;
        end else begin
            state_q       <= state_d;
            acc_cnt_q     <= acc_cnt_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            s1_valid_q    <= s1_valid_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_y_q        <= s1_y_d;
            s1_p_q        <= s1_p_d;
            sample_cnt_q  <= sample_cnt_d;
            correct_cnt_q <= correct_cnt_d;
            sum_ed_q      <= sum_ed_d;
            max_ed_q      <= max_ed_d;
            max_a_q       <= max_a_d;
            max_b_q       <= max_b_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;
    assign correct_cnt = correct_cnt_q;
    assign sum_ed      = sum_ed_q;
    assign max_ed      = max_ed_q;
    assign max_a       = max_a_q;
    assign max_b       = max_b_q;

endmodule

// File: tb/tb_kul8_err_monitor.sv
// Directed bench for kul8_err_monitor (4-sample windows); window results are
// queued as expected records and compared by a monitor when done rises.
module tb_kul8_err_monitor;

    typedef struct {
        logic [16:0] sc;
        logic [16:0] cc;
        logic [31:0] sum;
        logic [15:0] mx;
        logic [7:0]  ma;
        logic [7:0]  mb;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [16:0] sample_cnt;
    logic [16:0] correct_cnt;
    logic [31:0] sum_ed;
    logic [15:0] max_ed;
    logic [7:0]  max_a;
    logic [7:0]  max_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic done_prev = 1'b0;

    kul8_err_monitor #(.N_SAMPLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .y(y), .busy(busy), .done(done),
        .sample_cnt(sample_cnt), .correct_cnt(correct_cnt), .sum_ed(sum_ed),
        .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: compare the queued expected record whenever a window completes.
    always @(negedge clk) begin
        done_prev <= (done === 1'b1);
        if ((done === 1'b1) && !done_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_done: got done with empty scoreboard (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("win_sample_cnt",  {15'd0, sample_cnt},  {15'd0, e.sc});
                check("win_correct_cnt", {15'd0, correct_cnt}, {15'd0, e.cc});
                check("win_sum_ed",      sum_ed,               e.sum);
                check("win_max_ed",      {16'd0, max_ed},      {16'd0, e.mx});
                check("win_max_a",       {24'd0, max_a},       {24'd0, e.ma});
                check("win_max_b",       {24'd0, max_b},       {24'd0, e.mb});
            end
        end
    end

    task automatic cycle(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [15:0] yy);
        in_valid = v;
        a        = aa;
        b        = bb;
        y        = yy;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called right after the last accept edge: in_ready low now, done two edges later.
    task automatic finish_window(input string tag);
        check({tag, "_ready_drop"}, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_early"}, {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   {31'd0, in_ready},   32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_sample_cnt", {15'd0, sample_cnt}, 32'd0);
        check("rst_sum_ed",     sum_ed,              32'd0);
        rst = 1'b0;
        // IDLE ignores in_valid
        cycle(1'b1, 8'd9, 8'd9, 16'd0);
        cycle(1'b1, 8'd9, 8'd9, 16'd0);
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        // Window 1: mixed exact and under-estimates
        sb_q.push_back('{17'd4, 17'd2, 32'd12, 16'd10, 8'd10, 8'd10});
        pulse_start();
        check("w1_ready", {31'd0, in_ready}, 32'd1);
        check("w1_busy",  {31'd0, busy},     32'd1);
        cycle(1'b1, 8'd3,   8'd5,   16'd15);
        cycle(1'b1, 8'd255, 8'd255, 16'd65025);
        cycle(1'b1, 8'd2,   8'd3,   16'd4);
        cycle(1'b1, 8'd10,  8'd10,  16'd90);
        finish_window("w1");
        // DONE ignores in_valid and holds results
        cycle(1'b1, 8'd200, 8'd1, 16'd0);
        cycle(1'b1, 8'd200, 8'd1, 16'd0);
        check("done_hold_cnt",  {15'd0, sample_cnt}, 32'd4);
        check("done_hold_done", {31'd0, done},       32'd1);

        // Window 2: over-estimates and a tie on max_ed (earlier sample kept)
        sb_q.push_back('{17'd4, 17'd2, 32'd2, 16'd1, 8'd2, 8'd3});
        pulse_start();
        check("w2_cleared", {15'd0, sample_cnt}, 32'd0);
        cycle(1'b1, 8'd2, 8'd3, 16'd7);
        cycle(1'b1, 8'd4, 8'd4, 16'd15);
        cycle(1'b1, 8'd1, 8'd1, 16'd1);
        cycle(1'b1, 8'd0, 8'd0, 16'd0);
        finish_window("w2");

        // Window 3: gapped in_valid 1,0,0,1,0,1,1
        sb_q.push_back('{17'd4, 17'd2, 32'd65, 16'd56, 8'd16, 8'd16});
        pulse_start();
        cycle(1'b1, 8'd7,   8'd7,   16'd49);
        cycle(1'b0, 8'd99,  8'd99,  16'd1);
        cycle(1'b0, 8'd99,  8'd99,  16'd1);
        cycle(1'b1, 8'd16,  8'd16,  16'd200);
        cycle(1'b0, 8'd99,  8'd99,  16'd1);
        cycle(1'b1, 8'd9,   8'd9,   16'd90);
        cycle(1'b1, 8'd200, 8'd100, 16'd20000);
        finish_window("w3");

        // Abort after 2 accepts; start wins over a same-cycle sample
        pulse_start();
        cycle(1'b1, 8'd1, 8'd2, 16'd3);
        cycle(1'b1, 8'd5, 8'd5, 16'd20);
        sb_q.push_back('{17'd4, 17'd1, 32'd47, 16'd44, 8'd12, 8'd12});
        in_valid = 1'b1; a = 8'd50; b = 8'd50; y = 16'd0;
        pulse_start();
        in_valid = 1'b0;
        check("abort_cnt",   {15'd0, sample_cnt}, 32'd0);
        check("abort_sum",   sum_ed,              32'd0);
        check("abort_ready", {31'd0, in_ready},   32'd1);
        cycle(1'b0, 8'd0, 8'd0, 16'd0);
        check("abort_cnt_next", {15'd0, sample_cnt}, 32'd0);
        check("abort_max_next", {16'd0, max_ed},     32'd0);
        cycle(1'b1, 8'd8,  8'd8,  16'd64);
        cycle(1'b1, 8'd12, 8'd12, 16'd100);
        cycle(1'b1, 8'd3,  8'd3,  16'd10);
        cycle(1'b1, 8'd6,  8'd7,  16'd40);
        finish_window("w4");

        // rst in RUN with sample_cnt=3
        pulse_start();
        cycle(1'b1, 8'd1, 8'd1, 16'd1);
        cycle(1'b1, 8'd2, 8'd2, 16'd4);
        cycle(1'b1, 8'd3, 8'd3, 16'd9);
        cycle(1'b0, 8'd0, 8'd0, 16'd0);
        cycle(1'b0, 8'd0, 8'd0, 16'd0);
        check("pre_rst_cnt", {15'd0, sample_cnt}, 32'd3);
        rst = 1'b1;
        cycle(1'b1, 8'd4, 8'd4, 16'd0);
        rst = 1'b0;
        check("mid_rst_cnt",     {15'd0, sample_cnt},  32'd0);
        check("mid_rst_correct", {15'd0, correct_cnt}, 32'd0);
        check("mid_rst_sum",     sum_ed,               32'd0);
        check("mid_rst_busy",    {31'd0, busy},        32'd0);
        check("mid_rst_ready",   {31'd0, in_ready},    32'd0);
        cycle(1'b1, 8'd4, 8'd4, 16'd0);
        cycle(1'b1, 8'd4, 8'd4, 16'd0);
        cycle(1'b0, 8'd0, 8'd0, 16'd0);
        check("post_rst_cnt",  {15'd0, sample_cnt}, 32'd0);
        check("post_rst_done", {31'd0, done},       32'd0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kul8_err_monitor.md
# kul8_err_monitor

Downstream error-statistics stage for the 8-bit Kulkarni approximate multiplier. Accepts streamed operand/product triples (a, b, approximate Y), computes the exact product internally, and accumulates sample count, exact-match count, sum of error distance and worst-case error with its operands. It sits directly after the multiplier in hardware characterisation runs and replaces software-side accuracy tallying.

## Interface
- N_SAMPLES, 65536: samples per measurement window; legal range 1..65536.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; clears all statistics and opens a new window.
- in_valid  in  1  a/b/y carry a sample this cycle.
- in_ready  out  1  monitor accepts a sample this cycle.
- a  in  8  multiplier operand A (unsigned).
- b  in  8  multiplier operand B (unsigned).
- y  in  16  approximate product under test (unsigned).
- busy  out  1  window open or pipeline draining.
- done  out  1  window complete; statistics final and stable.
- sample_cnt  out  17  samples accumulated.
- correct_cnt  out  17  samples with y == a*b.
- sum_ed  out  32  sum of |a*b - y| over accumulated samples.
- max_ed  out  16  largest single |a*b - y|.
- max_a, max_b  out  8 each  operands of the first sample reaching max_ed.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset -> IDLE.
- IDLE: in_ready=0, busy=0, done=0. start -> RUN, statistics cleared.
- RUN: in_ready=1 while accepted count < N_SAMPLES. Sample accepted on in_valid && in_ready. Accepting the N_SAMPLES-th sample -> DRAIN; in_ready drops the next cycle.
- DRAIN: in_ready=0; waits until both pipeline stages are empty -> DONE.
- DONE: done=1, outputs held; in_valid ignored. start -> RUN with cleared statistics.
- start in RUN or DRAIN: abort; in-flight samples discarded (not accumulated), statistics cleared, window restarts in RUN.
- start takes priority over a same-cycle in_valid: that sample is not accepted.
- Pipeline: stage 1 registers a, b, y and exact p = a*b (16-bit, unsigned); stage 2 computes ed = |p - y| (either direction, 16-bit) and updates accumulators.
- Accumulation per sample: sample_cnt += 1; correct_cnt += (ed == 0); sum_ed += ed; if ed > max_ed (strict) update max_ed, max_a, max_b — ties keep the earlier sample.
- Widths suffice without overflow: ed <= 65535; 65536 x 65535 < 2^32. No saturation logic.
- in_valid gaps in RUN are legal; stages hold no bubble-specific state beyond a valid bit each.

## Timing
- Reset values: in_ready=0, busy=0, done=0, all statistics 0, state IDLE, stage valid bits 0.
- start at edge t: RUN from t; in_ready=1 and busy=1 in the cycle after t.
- Sample accepted at edge k: in stage 1 after k; reflected in statistics outputs after edge k+1 (latency 2 edges).
- Last sample accepted at edge k: state DRAIN after k; done=1 and busy=0 after edge k+2; statistics final at the same time.
- Statistics outputs are registers; they change only on accumulation, start, or rst.
- rst mid-window: all state and statistics return to reset values on that edge; no partial results retained.

## Test plan
- Exact model, N_SAMPLES=65536, exhaustive a,b with y=a*b, in_valid held high -> done after 65536+2 accept-edges; correct_cnt=65536, sum_ed=0, max_ed=0, max_a=max_b=0.
- N_SAMPLES=4, samples (3,5,15), (255,255,65025), (2,3,4), (10,10,90) -> sample_cnt=4, correct_cnt=2, sum_ed=12, max_ed=10, max_a=10, max_b=10.
- Over-estimate and tie: N_SAMPLES=3, (2,3,7), (4,4,15), (1,1,1) -> ed=1,1,0; correct_cnt=1, sum_ed=2, max_ed=1, max_a=2, max_b=3.
- Gapped input: N_SAMPLES=4, in_valid toggled 1,0,0,1,0,1,1 -> exactly 4 samples accepted; in_ready low from the cycle after the 4th accept; done 2 edges later.
- Abort: start pulsed after 2 of 4 samples accepted (one in flight) -> statistics read 0 the next cycle; a fresh 4-sample window then gives results for those 4 only.
- rst asserted in RUN with sample_cnt=3 -> next cycle all outputs 0, state IDLE; in_valid ignored until start.
